// File: rtl/spart_tx_buffered.sv
// SPART transmitter: a small byte FIFO feeding an 8N1 serialiser.
// Bit period comes from divisor_buffer, latched at each frame start.
module spart_tx_buffered #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_begin,
  input  logic [7:0]       transmit_buffer,
  input  logic [DIV_W-1:0] divisor_buffer,
  output logic             tbr,
  output logic             txd,
  output logic             tx_busy,
  output logic             tx_ovr
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] Full = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e           state_q, state_d;
  logic [7:0]       mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [DIV_W-1:0] period_q, baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             tbr_q, ovr_q;
  logic             push, pop, baud_done;

  // A write into a full FIFO is dropped even if a pop frees a slot on the same edge.
  assign push      = tx_begin && (count_q != Full);
  assign baud_done = (baud_q == period_q - 1'b1);
  assign count_d   = count_q + CW'(push) - CW'(pop);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        txd_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = StStart;
          baud_d  = '0;
          txd_d   = 1'b0;
        end
      end
      StStart: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
          txd_d   = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (baud_done) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = StStart;
            txd_d   = 1'b0;
          end else begin
            state_d = StIdle;
            txd_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) shift_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      period_q <= DIV_W'(2);
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      tbr_q    <= 1'b1;
      ovr_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      count_q <= count_d;
      tbr_q   <= (count_d != Full);
      ovr_q   <= tx_begin && (count_q == Full);
      if (push) begin
        mem_q[wr_ptr_q] <= transmit_buffer;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        period_q <= (divisor_buffer < DIV_W'(2)) ? DIV_W'(2) : divisor_buffer;
      end
    end
  end

  assign txd     = txd_q;
  assign tbr     = tbr_q;
  assign tx_ovr  = ovr_q;
  assign tx_busy = (state_q != StIdle) || (count_q != '0);

endmodule

// File: doc/spart_tx_buffered.md
Name: spart_tx_buffered

Overview:
Transmit half of the SPART serial port. It accepts bytes from the bus-side control logic into a small FIFO. It serialises each byte onto txd as an 8N1 frame: one start bit, eight data bits LSB first, one stop bit. Bit timing comes from the programmed divisor_buffer value. It is the counterpart to the SPART receiver; its txd is looped into rxd in system benches.

Parameters:
DEPTH, 4, FIFO entries; must be a power of 2, minimum 2.
DIV_W, 16, width of divisor_buffer.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
tx_begin  input  1  write strobe; enqueue transmit_buffer this cycle
transmit_buffer  input  8  byte to enqueue
divisor_buffer  input  DIV_W  clocks per serial bit
tbr  output  1  transmit buffer ready (FIFO not full)
txd  output  1  serial output, idle high
tx_busy  output  1  frame in progress or FIFO non-empty
tx_ovr  output  1  one-cycle pulse when a write is dropped

Behaviour:
- Reset values (asynchronous, immediate): txd=1, tbr=1, tx_busy=0, tx_ovr=0, FIFO empty (count=0, pointers=0), FSM=IDLE, baud and bit counters=0.
- FIFO write: on each rising edge with tx_begin=1 and count<DEPTH, the byte is stored and count is incremented.
- Write while full: the write is dropped even if a pop occurs in the same cycle. tx_ovr pulses high for exactly the next cycle. FIFO contents are unchanged.
- tbr = (count != DEPTH). It is registered and reflects count after the current edge.
- Simultaneous write and pop when not full: both occur and count is unchanged.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits wide.
- Effective bit period P = divisor_buffer, latched into an internal register when a frame starts. Latched values below 2 are forced to 2. A divisor change mid-frame does not affect the current frame.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: txd=1. When count>0 at a rising edge: pop the head byte into the shift register, latch P, clear the baud counter, go to START. txd=0 takes effect on the same edge.
- START: txd=0 for P cycles, then go to DATA with bit index 0.
- DATA: txd=shift[0] for P cycles per bit, then shift right. After bit index 7 completes, go to STOP.
- STOP: txd=1 for P cycles. Then go back-to-back to START if count>0 (pop on the same edge, no idle gap). Otherwise go to IDLE.
- Frame length is exactly 10*P clocks.
- Latency: with tx_begin sampled at edge E0, FIFO empty and FSM IDLE, txd falls at edge E1.
- The baud counter counts 0..P-1 and advances state/bit on the edge where it equals P-1.
- tx_busy = (state != IDLE) || (count != 0).
- txd is driven from a flop, with no combinational path from inputs.
- Reset asserted mid-frame aborts the frame: txd goes high immediately and the FIFO is flushed. After reset is released, nothing is transmitted until a new write.

Test Plan:
- Reset/idle: assert rst for 2 cycles, release, hold 20 cycles -> txd=1, tbr=1, tx_busy=0, tx_ovr=0 throughout.
- Single byte, divisor=4: write 8'hA5 -> txd falls one edge later, then levels 0,1,0,1,0,0,1,0,1,1, each exactly 4 cycles. tx_busy deasserts after 40 cycles.
- Back-to-back, divisor=4: write 8'hA5, 8'hE7, 8'h24 on consecutive cycles -> three frames with no idle gap between stop and start bits; decoded bytes A5, E7, 24 in order.
- Full/overflow, divisor=8: write 6 bytes on consecutive cycles -> tbr drops after the FIFO fills (first byte already popped). Exactly one write is dropped, with one tx_ovr pulse. The 5 accepted bytes are transmitted in order.
- Divisor floor and change: divisor=0 gives 2-cycle bits. Changing divisor from 4 to 2604 mid-frame leaves the frame at 4-cycle bits; the next frame uses 2604-cycle bits.
- Reset mid-frame: assert rst during DATA bit 3 with 2 bytes queued -> txd=1 immediately and tbr=1. No further frames after release.
